puf_eval_ctrl: RTL

Sequencing controller for the PUF SoC datapath. It collects a challenge frame from the host over the RX valid/ready link, drives the challenge into the PUF core, and runs and times the evaluation. It then returns the response over the TX valid/ready link: one word in normal mode, or the response plus the evaluation cycle count in debug mode. It sits between the host link interfaces and the PUF core inside puf_soc_top.

---
 rtl/puf_eval_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/puf_eval_ctrl.sv
// Sequencing controller for the PUF datapath: collects a challenge frame over RX,
// runs and times the PUF evaluation, and returns the response (plus cycle count in debug mode) over TX.
module puf_eval_ctrl #(
    parameter int       REG_BIT_SIZE = 8,
    parameter int       FRAM_SIZE    = 4,
    parameter int       PUF_LENGTH   = 32,
    parameter int       CNT_BIT_SIZE = 8,
    parameter logic     NORM_MOD     = 1'b0,
    parameter logic     DEBUG_MOD    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_op_mode,
    output logic                    o_rx_ready,
    input  logic                    i_rx_valid,
    input  logic [REG_BIT_SIZE-1:0] i_rx_data,
    output logic [PUF_LENGTH-1:0]   o_chal,
    output logic                    o_puf_en,
    input  logic                    i_puf_valid,
    input  logic [REG_BIT_SIZE-1:0] i_puf_resp,
    input  logic                    i_tx_ready,
    output logic [REG_BIT_SIZE-1:0] o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int IDX_W = (FRAM_SIZE > 1) ? $clog2(FRAM_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_CHAL = 3'd1,
        EVAL    = 3'd2,
        TX_RESP = 3'd3,
        TX_CNT  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_BIT_SIZE-1:0] cnt_r;
    logic [CNT_BIT_SIZE-1:0] cnt_cap_r;
    logic                    mode_r;

    logic                    rx_acc_s;
    logic                    last_word_s;
    logic                    tx_hs_s;
    logic                    term_s;
    logic                    debug_s;
    logic [CNT_BIT_SIZE+REG_BIT_SIZE-1:0] cnt_ext_s;
    logic [REG_BIT_SIZE-1:0] cnt_word_s;

    // Handshake decodes and the zero-extended/truncated count word
    always_comb begin
        rx_acc_s    = (state_r == RX_CHAL) && i_rx_valid && o_rx_ready;
        last_word_s = (idx_r == IDX_W'(FRAM_SIZE - 1));
        tx_hs_s     = o_tx_valid && i_tx_ready;
        term_s      = (cnt_r == {CNT_BIT_SIZE{1'b1}});
        debug_s     = (mode_r == DEBUG_MOD);
        cnt_ext_s   = {{REG_BIT_SIZE{1'b0}}, cnt_cap_r};
        cnt_word_s  = cnt_ext_s[REG_BIT_SIZE-1:0];
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) state_s = RX_CHAL;
                else         state_s = IDLE;
            end
            RX_CHAL: begin
                if (rx_acc_s && last_word_s) state_s = EVAL;
                else                         state_s = RX_CHAL;
            end
            EVAL: begin
                // A response in the terminal-count cycle still counts as a response
                if (i_puf_valid || term_s) state_s = TX_RESP;
                else                       state_s = EVAL;
            end
            TX_RESP: begin
                if (tx_hs_s) state_s = debug_s ? TX_CNT : IDLE;
                else         state_s = TX_RESP;
            end
            TX_CNT: begin
                if (tx_hs_s) state_s = IDLE;
                else         state_s = TX_CNT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Datapath and registered outputs, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_ready <= 1'b0;
            o_puf_en   <= 1'b0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_chal     <= {PUF_LENGTH{1'b0}};
            o_tx_data  <= {REG_BIT_SIZE{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            cnt_r      <= {CNT_BIT_SIZE{1'b0}};
            cnt_cap_r  <= {CNT_BIT_SIZE{1'b0}};
            mode_r     <= NORM_MOD;
        end else begin
            o_rx_ready <= (state_s == RX_CHAL);
            o_puf_en   <= (state_s == EVAL);
            o_tx_valid <= (state_s == TX_RESP) || (state_s == TX_CNT);
            o_busy     <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        mode_r    <= i_op_mode;
                        o_timeout <= 1'b0;
                        idx_r     <= {IDX_W{1'b0}};
                    end
                end
                RX_CHAL: begin
                    cnt_r <= {CNT_BIT_SIZE{1'b0}};
                    if (rx_acc_s) begin
                        o_chal[idx_r*REG_BIT_SIZE +: REG_BIT_SIZE] <= i_rx_data;
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                EVAL: begin
                    cnt_r <= cnt_r + CNT_BIT_SIZE'(1);
                    if (i_puf_valid) begin
                        o_tx_data <= i_puf_resp;
                        cnt_cap_r <= cnt_r;
                    end else if (term_s) begin
                        o_timeout <= 1'b1;
                        o_tx_data <= {REG_BIT_SIZE{1'b1}};
                        cnt_cap_r <= cnt_r;
                    end
                end
                TX_RESP: begin
                    if (tx_hs_s && debug_s) o_tx_data <= cnt_word_s;
                end
                TX_CNT: begin
                    cnt_r <= {CNT_BIT_SIZE{1'b0}};
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule
